char_lcd_sequencer: RTL

//  Write-only HD44780 sequencer for the 16x2 character LCD on the LCD_* pins.
//  - Runs the power-up init sequence on its own, then accepts byte requests on a valid/ready handshake.
//  - Generates RS/EN/DATA timing and the per-command execution wait.
//  - Lets game logic post characters without a soft core. Top level drives LCD_DATA from lcd_data (RW fixed 0).

---
 rtl/char_lcd_pkg.sv | 68 ++++++
 rtl/char_lcd_delay_timer.sv | 49 ++++
 rtl/char_lcd_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/char_lcd_pkg.sv
// char_lcd_pkg: shared types and constants for the HD44780 character LCD sequencer.
package char_lcd_pkg;

  // Sequencer states. A transfer always runs SETUP -> EN_HI -> WAIT.
  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_SETUP,
    ST_EN_HI,
    ST_WAIT,
    ST_IDLE
  } lcd_state_e;

  // Which execution wait follows the current transfer.
  typedef enum logic [1:0] {
    WAIT_INIT1,
    WAIT_CMD,
    WAIT_LONG
  } wait_kind_e;

  // HD44780 command codes.
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;
  localparam logic [7:0] LINE1_ADDR     = 8'h40;
  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;  // increment, no shift

  localparam int         INIT_LEN  = 6;
  localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

  // Power-up init ROM: command byte for each entry.
  function automatic logic [7:0] init_rom_data(input logic [2:0] idx);
    unique case (idx)
      3'd0, 3'd1, 3'd2: init_rom_data = CMD_FUNC_SET;
      3'd3:             init_rom_data = CMD_DISP_ON;
      3'd4:             init_rom_data = CMD_CLEAR;
      default:          init_rom_data = CMD_ENTRY_MODE;
    endcase
  endfunction

  // Power-up init ROM: execution wait after each entry.
  function automatic wait_kind_e init_rom_wait(input logic [2:0] idx);
    unique case (idx)
      3'd0:    init_rom_wait = WAIT_INIT1;
      3'd4:    init_rom_wait = WAIT_LONG;
      default: init_rom_wait = WAIT_CMD;
    endcase
  endfunction

  // Clear display (01) and return home (02/03) need the long execution wait.
  function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
    is_clear_home = !rs && (data == CMD_CLEAR || data == CMD_HOME ||
                            data == (CMD_CLEAR | CMD_HOME));
  endfunction

  // Set-DDRAM-address command with a line/column we can track.
  function automatic logic is_set_ddram(input logic rs, input logic [7:0] data);
    is_set_ddram = !rs && data[7] && (data[5:4] == 2'b00);
  endfunction

  // Address command that moves the cursor to the start of the other line.
  function automatic logic [7:0] wrap_addr_cmd(input logic line);
    wrap_addr_cmd = line ? CMD_SET_DDRAM : (CMD_SET_DDRAM | LINE1_ADDR);
  endfunction

endpackage

// File: rtl/char_lcd_delay_timer.sv
// char_lcd_delay_timer: loadable down-counter. Loading len_i makes done_o pulse
// in the len_i-th cycle after the load edge, so a state that loads on entry and
// leaves on done_o lasts exactly len_i cycles. Reset behaves like a load of RESET_LEN.
module char_lcd_delay_timer #(
  parameter int unsigned W         = 20,
  parameter int unsigned RESET_LEN = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] len_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  // Next count: reload, or count down to zero and stop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_i) begin
      cnt_d = len_i - W'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  // Counter registers; reset starts the power-up delay.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!reset_n) begin
      cnt_q <= W'(RESET_LEN - 1);
      run_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/char_lcd_sequencer.sv
// char_lcd_sequencer: write-only HD44780 sequencer for a 16x2 character LCD.
// Runs the power-up init ROM, then transfers bytes posted on a valid/ready
// handshake, generating RS/DATA setup, the EN pulse and the execution wait.
// Optional: define LCD_LINE_WRAP_EN to track the cursor and automatically move
// to the other line after the 16th character.
module char_lcd_sequencer
  import char_lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_SETUP   = 3,
  parameter int unsigned T_EN      = 12,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_LONG    = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic       lcd_blon
);

  // One counter serves every delay, so it is sized for the longest (power-up).
  localparam int unsigned   CW        = $clog2(T_POWERUP + 1);
  localparam logic [CW-1:0] LEN_SETUP = CW'(T_SETUP);
  localparam logic [CW-1:0] LEN_EN    = CW'(T_EN);
  localparam logic [CW-1:0] LEN_INIT1 = CW'(T_INIT1);
  localparam logic [CW-1:0] LEN_CMD   = CW'(T_CMD);
  localparam logic [CW-1:0] LEN_LONG  = CW'(T_LONG);

  lcd_state_e    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          init_done_q, init_done_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  wait_kind_e    wait_q, wait_d;
  logic          en_q, ready_q, on_q;

  logic          issue;
  logic          issue_rs;
  logic [7:0]    issue_data;
  wait_kind_e    issue_wait;

  logic          tmr_load;
  logic [CW-1:0] tmr_len;
  logic          tmr_done;
  logic [CW-1:0] wait_len;

`ifdef LCD_LINE_WRAP_EN
  localparam logic [4:0] COL_FULL = 5'd16;
  logic [4:0] col_q, col_d;
  logic       line_q, line_d;
`endif

  char_lcd_delay_timer #(
    .W         (CW),
    .RESET_LEN (T_POWERUP)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (tmr_load),
    .len_i   (tmr_len),
    .done_o  (tmr_done)
  );

  // Execution-wait length for the transfer in flight.
  always_comb begin
    unique case (wait_q)
      WAIT_INIT1: wait_len = LEN_INIT1;
      WAIT_LONG:  wait_len = LEN_LONG;
      default:    wait_len = LEN_CMD;
    endcase
  end

  // Next state, timer control and transfer launch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    data_d      = data_q;
    rs_d        = rs_q;
    wait_d      = wait_q;
    tmr_load    = 1'b0;
    tmr_len     = LEN_SETUP;
    issue       = 1'b0;
    issue_rs    = 1'b0;
    issue_data  = 8'h00;
    issue_wait  = WAIT_CMD;

    unique case (state_q)
      ST_PWR_WAIT: begin
        if (tmr_done) state_d = ST_INIT;
      end
      ST_INIT: begin
        issue      = 1'b1;
        issue_data = init_rom_data(idx_q);
        issue_wait = init_rom_wait(idx_q);
      end
      ST_IDLE: begin
        if (req_valid) begin
          issue      = 1'b1;
          issue_rs   = req_rs;
          issue_data = req_data;
          issue_wait = is_clear_home(req_rs, req_data) ? WAIT_LONG : WAIT_CMD;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_EN_HI;
          tmr_load = 1'b1;
          tmr_len  = LEN_EN;
        end
      end
      ST_EN_HI: begin
        if (tmr_done) begin
          state_d  = ST_WAIT;
          tmr_load = 1'b1;
          tmr_len  = wait_len;
        end
      end
      ST_WAIT: begin
        if (tmr_done) begin
          if (!init_done_q) begin
            if (idx_q == INIT_LAST) begin
              init_done_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = ST_INIT;
            end
          end
`ifdef LCD_LINE_WRAP_EN
          else if (col_q == COL_FULL) begin
            issue      = 1'b1;
            issue_data = wrap_addr_cmd(line_q);
            issue_wait = WAIT_CMD;
          end
`endif
          else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_PWR_WAIT;
    endcase

    // Every launch latches RS/DATA and starts the setup delay.
    if (issue) begin
      state_d  = ST_SETUP;
      tmr_load = 1'b1;
      tmr_len  = LEN_SETUP;
      rs_d     = issue_rs;
      data_d   = issue_data;
      wait_d   = issue_wait;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_PWR_WAIT;
    else          state_q <= state_d;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q       <= 3'd0;
      init_done_q <= 1'b0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      wait_q      <= WAIT_CMD;
      en_q        <= 1'b0;
      ready_q     <= 1'b0;
      on_q        <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      wait_q      <= wait_d;
      en_q        <= (state_d == ST_EN_HI);
      ready_q     <= (state_d == ST_IDLE);
      on_q        <= 1'b1;
    end
  end

`ifdef LCD_LINE_WRAP_EN
  // Cursor tracking, updated as each byte is launched.
  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (issue) begin
      if (issue_rs) begin
        col_d = col_q + 5'd1;
      end else if (is_clear_home(1'b0, issue_data)) begin
        col_d  = 5'd0;
        line_d = 1'b0;
      end else if (is_set_ddram(1'b0, issue_data)) begin
        col_d  = {1'b0, issue_data[3:0]};
        line_d = issue_data[6];
      end
    end
  end

  // Cursor registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q  <= 5'd0;
      line_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      line_q <= line_d;
    end
  end
`endif

  assign req_ready = ready_q;
  assign init_done = init_done_q;
  assign lcd_data  = data_q;
  assign lcd_rs    = rs_q;
  assign lcd_en    = en_q;
  assign lcd_rw    = 1'b0;
  assign lcd_on    = on_q;
  assign lcd_blon  = on_q;

endmodule
